// File: rtl/arb_requester.sv
// Requester-side client of a 4-phase req/gnt arbiter: takes a burst job,
// requests the bus, streams one beat per granted cycle, then releases.
module arb_requester #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             req,
  input  logic             gnt,
  output logic             xfer_en,
  output logic             done,
  output logic             timeout,
  output logic             busy
);

  // A zero TIMEOUT disables the wait limit, but the counter keeps one bit.
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } stateT;

  stateT             r_state;
  logic              r_req;
  logic              r_done;
  logic              r_timeout;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beatCnt;
  logic [WAIT_W-1:0] r_waitCnt;

  stateT             w_nextState;
  logic              w_nextReq;
  logic              w_nextDone;
  logic              w_nextTimeout;
  logic [LEN_W-1:0]  w_nextLen;
  logic [LEN_W-1:0]  w_nextBeat;
  logic [WAIT_W-1:0] w_nextWait;
  logic              w_accept;
  logic              w_lastBeat;

  assign w_accept   = job_valid && (r_state == IDLE);
  assign w_lastBeat = (r_beatCnt == LEN_W'(r_len - LEN_W'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_len     <= '0;
      r_beatCnt <= '0;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_req     <= w_nextReq;
      r_done    <= w_nextDone;
      r_timeout <= w_nextTimeout;
      r_len     <= w_nextLen;
      r_beatCnt <= w_nextBeat;
      r_waitCnt <= w_nextWait;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextReq     = r_req;
    w_nextDone    = 1'b0;
    w_nextTimeout = 1'b0;
    w_nextLen     = r_len;
    w_nextBeat    = r_beatCnt;
    w_nextWait    = r_waitCnt;
    unique case (r_state)
      IDLE: begin
        w_nextReq = 1'b0;
        if (w_accept) begin
          w_nextLen  = job_len;
          w_nextBeat = '0;
          if (job_len == '0) begin
            w_nextDone = 1'b1;
          end else begin
            w_nextState = REQ;
            w_nextReq   = 1'b1;
            w_nextWait  = '0;
          end
        end
      end
      REQ: begin
        if (gnt) begin
          w_nextState = XFER;
        end else if ((TIMEOUT != 0) && (r_waitCnt == WAIT_LAST)) begin
          w_nextState   = REL;
          w_nextReq     = 1'b0;
          w_nextTimeout = 1'b1;
        end else if (r_waitCnt != WAIT_MAX) begin
          w_nextWait = r_waitCnt + WAIT_W'(1);
        end
      end
      XFER: begin
        // A dropped grant pauses the burst; there is no limit on the pause.
        if (gnt) begin
          if (w_lastBeat) begin
            w_nextState = REL;
            w_nextReq   = 1'b0;
            w_nextDone  = 1'b1;
          end else begin
            w_nextBeat = r_beatCnt + LEN_W'(1);
          end
        end
      end
      REL: begin
        w_nextReq = 1'b0;
        if (!gnt) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextReq   = 1'b0;
      end
    endcase
  end

  assign job_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign xfer_en   = (r_state == XFER) && gnt;
  assign req       = r_req;
  assign done      = r_done;
  assign timeout   = r_timeout;

endmodule
